snn_layer_scheduler: RTL and testbench

Time-multiplexed controller for one fully connected layer of leaky-integrate-fire neurons. A single shared LIF update datapath serves all neurons, one neuron per clock. Per-neuron membrane potentials, refractory counters and the synapse weight RAM are held locally. Spike vectors enter and leave through valid/ready handshakes, so layers chain as a pipeline of timesteps.

---
 rtl/snn_pkg.sv | 34 +++
 rtl/snn_layer_scheduler_lif_update_unit.sv | 50 +++++
 rtl/snn_layer_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_snn_layer_scheduler.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared widths, scheduler state encoding, reset defaults and the potential clamp
// used by the LIF layer scheduler and its update datapath.
package snn_pkg;

    localparam int DEFAULT_NUM_NEURONS = 8;
    localparam int PW = 8;
    localparam int WW = 8;
    localparam int TW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        OUTPUT = 2'd2
    } sched_state_e;

    localparam sched_state_e RST_STATE     = IDLE;
    localparam logic         RST_IN_READY  = 1'b1;
    localparam logic         RST_OUT_VALID = 1'b0;
    localparam logic         RST_BUSY      = 1'b0;

    // Saturate a signed intermediate sum into the unsigned potential range.
    function automatic logic [PW-1:0] clamp_potential(input logic signed [31:0] s);
        logic signed [31:0] max_v;
        max_v = (32'sd1 <<< PW) - 32'sd1;
        if (s < 32'sd0) begin
            clamp_potential = {PW{1'b0}};
        end else if (s > max_v) begin
            clamp_potential = {PW{1'b1}};
        end else begin
            clamp_potential = s[PW-1:0];
        end
    endfunction

endpackage

// File: rtl/snn_layer_scheduler_lif_update_unit.sv
// Combinational single-neuron leaky-integrate-fire update: integrates the weighted
// input spikes, applies leak and clamping, and handles threshold and refractory logic.
module lif_update_unit
    import snn_pkg::*;
#(
    parameter int NUM_NEURONS = DEFAULT_NUM_NEURONS
) (
    input  logic [PW-1:0]             v,
    input  logic [TW-1:0]             refr,
    input  logic [NUM_NEURONS*WW-1:0] w_row,
    input  logic [NUM_NEURONS-1:0]    in_spike,
    input  logic [PW-1:0]             threshold,
    input  logic [PW-1:0]             leak_value,
    input  logic [TW-1:0]             tref,
    output logic [PW-1:0]             v_next,
    output logic [TW-1:0]             refr_next,
    output logic                      spike
);

    localparam int AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int SW = PW + WW + AW + 1;

    logic signed [SW-1:0] acc_s;
    logic [PW-1:0]        pot_s;

    // Weighted sum, leak, clamp and fire decision for the selected neuron
    always_comb begin
        acc_s = $signed({{(SW-PW){1'b0}}, v}) - $signed({{(SW-PW){1'b0}}, leak_value});
        for (int j = 0; j < NUM_NEURONS; j++) begin
            if (in_spike[j]) begin
                acc_s = acc_s + $signed({{(SW-WW){w_row[j*WW+WW-1]}}, w_row[j*WW +: WW]});
            end else begin
                acc_s = acc_s;
            end
        end
        pot_s     = clamp_potential({{(32-SW){acc_s[SW-1]}}, acc_s});
        v_next    = {PW{1'b0}};
        refr_next = {TW{1'b0}};
        spike     = 1'b0;
        if (refr != {TW{1'b0}}) begin
            refr_next = refr - {{(TW-1){1'b0}}, 1'b1};
        end else if (pot_s >= threshold) begin
            refr_next = tref;
            spike     = 1'b1;
        end else begin
            v_next = pot_s;
        end
    end

endmodule

// File: rtl/snn_layer_scheduler.sv
// Time-multiplexed scheduler for one fully connected LIF layer: owns potentials,
// refractory counters and weights, and walks one neuron per clock per timestep.
module snn_layer_scheduler
    import snn_pkg::*;
#(
    parameter int NUM_NEURONS = DEFAULT_NUM_NEURONS
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_NEURONS-1:0]               in_spike,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [NUM_NEURONS-1:0]               out_spike,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    input  logic [PW-1:0]                        threshold,
    input  logic [PW-1:0]                        leak_value,
    input  logic [TW-1:0]                        tref,
    input  logic                                 cfg_we,
    input  logic [2*$clog2(NUM_NEURONS)-1:0]     cfg_addr,
    input  logic [WW-1:0]                        cfg_data,
    input  logic                                 clear_state,
    output logic                                 busy
);

    localparam int AW = $clog2(NUM_NEURONS);

    sched_state_e state_r, state_next_s;

    logic [PW-1:0]             v_r    [NUM_NEURONS];
    logic [TW-1:0]             refr_r [NUM_NEURONS];
    logic [NUM_NEURONS*WW-1:0] w_r    [NUM_NEURONS];

    logic [NUM_NEURONS-1:0] spike_in_r;
    logic [NUM_NEURONS-1:0] spike_vec_r;
    logic [NUM_NEURONS-1:0] spike_vec_next_s;
    logic [NUM_NEURONS-1:0] out_spike_r;
    logic [AW-1:0]          idx_r;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic                   busy_r;

    logic accept_s;
    logic clear_s;
    logic cfg_wr_s;
    logic update_s;
    logic last_s;

    logic [PW-1:0] v_next_s;
    logic [TW-1:0] refr_next_s;
    logic          spike_s;

    logic [AW-1:0] cfg_neuron_s;
    logic [AW-1:0] cfg_syn_s;

    assign cfg_neuron_s = cfg_addr[2*AW-1:AW];
    assign cfg_syn_s    = cfg_addr[AW-1:0];

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_spike = out_spike_r;
    assign busy      = busy_r;

    lif_update_unit #(
        .NUM_NEURONS (NUM_NEURONS)
    ) u_lif (
        .v          (v_r[idx_r]),
        .refr       (refr_r[idx_r]),
        .w_row      (w_r[idx_r]),
        .in_spike   (spike_in_r),
        .threshold  (threshold),
        .leak_value (leak_value),
        .tref       (tref),
        .v_next     (v_next_s),
        .refr_next  (refr_next_s),
        .spike      (spike_s)
    );

    // Next-state decode; config and clear are only honoured while idle, input wins over clear
    always_comb begin
        state_next_s     = state_r;
        accept_s         = 1'b0;
        clear_s          = 1'b0;
        cfg_wr_s         = 1'b0;
        update_s         = 1'b0;
        last_s           = 1'b0;
        spike_vec_next_s = spike_vec_r;
        spike_vec_next_s[idx_r] = spike_s;
        case (state_r)
            IDLE: begin
                cfg_wr_s = cfg_we;
                if (in_valid && in_ready_r) begin
                    accept_s     = 1'b1;
                    state_next_s = UPDATE;
                end else begin
                    clear_s = clear_state;
                end
            end
            UPDATE: begin
                update_s = 1'b1;
                if (idx_r == AW'(NUM_NEURONS - 1)) begin
                    last_s       = 1'b1;
                    state_next_s = OUTPUT;
                end else begin
                    state_next_s = UPDATE;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = OUTPUT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Control state, sequencing registers and registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= RST_STATE;
            in_ready_r  <= RST_IN_READY;
            out_valid_r <= RST_OUT_VALID;
            busy_r      <= RST_BUSY;
            out_spike_r <= {NUM_NEURONS{1'b0}};
            spike_in_r  <= {NUM_NEURONS{1'b0}};
            spike_vec_r <= {NUM_NEURONS{1'b0}};
            idx_r       <= {AW{1'b0}};
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == OUTPUT);
            busy_r      <= (state_next_s != IDLE);
            if (accept_s) begin
                spike_in_r  <= in_spike;
                spike_vec_r <= {NUM_NEURONS{1'b0}};
                idx_r       <= {AW{1'b0}};
            end else if (update_s) begin
                spike_vec_r <= spike_vec_next_s;
                idx_r       <= idx_r + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                spike_vec_r <= spike_vec_r;
                idx_r       <= idx_r;
            end
            if (last_s) begin
                out_spike_r <= spike_vec_next_s;
            end else begin
                out_spike_r <= out_spike_r;
            end
        end
    end

    // Per-neuron membrane potentials and refractory counters
    always_ff @(posedge clk) begin
        if (reset || clear_s) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                v_r[i]    <= {PW{1'b0}};
                refr_r[i] <= {TW{1'b0}};
            end
        end else if (update_s) begin
            v_r[idx_r]    <= v_next_s;
            refr_r[idx_r] <= refr_next_s;
        end else begin
            v_r[idx_r]    <= v_r[idx_r];
            refr_r[idx_r] <= refr_r[idx_r];
        end
    end

    // Synapse weight storage, one packed row per neuron
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                w_r[i] <= {(NUM_NEURONS*WW){1'b0}};
            end
        end else if (cfg_wr_s) begin
            w_r[cfg_neuron_s][cfg_syn_s*WW +: WW] <= cfg_data;
        end else begin
            w_r[cfg_neuron_s] <= w_r[cfg_neuron_s];
        end
    end

endmodule

// File: tb/tb_snn_layer_scheduler.sv
// Directed self-checking bench for snn_layer_scheduler with hand-computed spike vectors.
module tb_snn_layer_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_spike;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_spike;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] threshold;
    logic [7:0] leak_value;
    logic [3:0] tref;
    logic       cfg_we;
    logic [5:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       clear_state;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snn_layer_scheduler #(.NUM_NEURONS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_spike    (in_spike),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_spike   (out_spike),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .threshold   (threshold),
        .leak_value  (leak_value),
        .tref        (tref),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .clear_state (clear_state),
        .busy        (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input int n, input int s, input logic [7:0] val);
        cfg_we   = 1'b1;
        cfg_addr = {3'(n), 3'(s)};
        cfg_data = val;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_state = 1'b1;
        tick();
        clear_state = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: out_valid=%b required 1", name, out_valid);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_step(input string name, input logic [7:0] spk, output logic [7:0] got);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        in_spike = spk;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out(name);
        got = out_spike;
        consume();
    endtask

    task automatic test_reset();
        checks++;
        if ({in_ready, out_valid, busy, out_spike} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_outputs: got rdy/vld/busy/spk=%b%b%b/%h required 100/00",
                     in_ready, out_valid, busy, out_spike);
        end
    endtask

    task automatic test_zero_input();
        logic bad;
        in_spike = 8'h00;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL latency_early: out_valid=%b busy=%b required 0 1", out_valid, busy);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_spike !== 8'h00) begin
            errors++;
            $display("FAIL latency_on_time: out_valid=%b out_spike=%h required 1 00", out_valid, out_spike);
        end
        bad = 1'b0;
        for (int i = 0; i < 8; i++) if (dut.v_r[i] !== 8'd0) bad = 1'b1;
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL zero_input_v: some potential nonzero, required all 0 (v0=%0d)", dut.v_r[0]);
        end
        consume();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL return_idle: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_refractory();
        logic [7:0] got;
        logic [7:0] exp_tbl [6];
        exp_tbl = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        for (int j = 0; j < 8; j++) write_w(0, j, 8'h01);
        for (int s = 0; s < 6; s++) begin
            run_step("refr_step", 8'hFF, got);
            checks++;
            if (got !== exp_tbl[s]) begin
                errors++;
                $display("FAIL refr_step%0d: out_spike=%h required %h", s + 1, got, exp_tbl[s]);
            end
        end
        checks++;
        if (dut.v_r[0] !== 8'd7) begin
            errors++;
            $display("FAIL refr_v0_after: v0=%0d required 7", dut.v_r[0]);
        end
    endtask

    task automatic test_clamp();
        logic [7:0] got;
        pulse_clear();
        checks++;
        if (dut.v_r[0] !== 8'd0) begin
            errors++;
            $display("FAIL clear_idle: v0=%0d required 0", dut.v_r[0]);
        end
        for (int j = 0; j < 8; j++) write_w(6, j, 8'hEE);
        run_step("clamp_low", 8'hFF, got);
        checks++;
        if (got !== 8'h00 || dut.v_r[6] !== 8'd0) begin
            errors++;
            $display("FAIL clamp_low: out_spike=%h v6=%0d required 00 0", got, dut.v_r[6]);
        end
        for (int j = 0; j < 8; j++) write_w(6, j, 8'h7F);
        run_step("clamp_high", 8'hFF, got);
        checks++;
        if (got !== 8'h40 || dut.v_r[6] !== 8'd0 || dut.v_r[0] !== 8'd14) begin
            errors++;
            $display("FAIL clamp_high: out_spike=%h v6=%0d v0=%0d required 40 0 14", got, dut.v_r[6], dut.v_r[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        pulse_clear();
        in_spike = 8'hFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out("stall");
        checks++;
        if (out_spike !== 8'h40) begin
            errors++;
            $display("FAIL stall_first: out_spike=%h required 40", out_spike);
        end
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_spike !== 8'h40 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: vld=%b spk=%h rdy=%b required 1 40 0", k, out_valid, out_spike, in_ready);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: rdy=%b vld=%b busy=%b required 1 0 0", in_ready, out_valid, busy);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL second_accept: busy=%b rdy=%b required 1 0", busy, in_ready);
        end
        wait_out("second");
        got = out_spike;
        consume();
        checks++;
        if (got !== 8'h00) begin
            errors++;
            $display("FAIL second_result: out_spike=%h required 00", got);
        end
    endtask

    task automatic test_cfg();
        logic [7:0] got;
        pulse_clear();
        tref = 4'd0;
        in_spike = 8'h01;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        write_w(1, 0, 8'h30);
        wait_out("cfg_busy");
        got = out_spike;
        consume();
        checks++;
        if (got !== 8'h40 || dut.w_r[1] !== 64'd0) begin
            errors++;
            $display("FAIL cfg_busy_ignored: out_spike=%h w1=%h required 40 0", got, dut.w_r[1]);
        end
        run_step("cfg_next", 8'h01, got);
        checks++;
        if (got !== 8'h40) begin
            errors++;
            $display("FAIL cfg_next_step: out_spike=%h required 40", got);
        end
        cfg_we   = 1'b1;
        cfg_addr = {3'd1, 3'd0};
        cfg_data = 8'h30;
        in_spike = 8'h01;
        in_valid = 1'b1;
        tick();
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        wait_out("cfg_coincident");
        got = out_spike;
        consume();
        checks++;
        if (got !== 8'h42) begin
            errors++;
            $display("FAIL cfg_coincident: out_spike=%h required 42", got);
        end
    endtask

    task automatic test_clear_coincident();
        logic [7:0] got;
        run_step("pre_clear", 8'hFF, got);
        checks++;
        if (got !== 8'h42 || dut.v_r[0] !== 8'd7) begin
            errors++;
            $display("FAIL pre_clear: out_spike=%h v0=%0d required 42 7", got, dut.v_r[0]);
        end
        clear_state = 1'b1;
        in_spike    = 8'hFF;
        in_valid    = 1'b1;
        tick();
        clear_state = 1'b0;
        in_valid    = 1'b0;
        wait_out("clear_coincident");
        got = out_spike;
        consume();
        checks++;
        if (got !== 8'h42 || dut.v_r[0] !== 8'd14) begin
            errors++;
            $display("FAIL clear_coincident: out_spike=%h v0=%0d required 42 14", got, dut.v_r[0]);
        end
    endtask

    task automatic test_threshold_zero();
        logic [7:0] got;
        threshold = 8'h00;
        run_step("thr0", 8'h00, got);
        checks++;
        if (got !== 8'hFF) begin
            errors++;
            $display("FAIL threshold_zero: out_spike=%h required ff", got);
        end
        threshold = 8'h15;
    endtask

    task automatic test_reset_mid_update();
        logic [7:0] got;
        logic       bad;
        tref = 4'd2;
        in_spike = 8'hFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (dut.idx_r !== 3'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_update_pos: idx=%0d busy=%b required 3 1", dut.idx_r, busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_ctrl: rdy=%b vld=%b busy=%b required 1 0 0", in_ready, out_valid, busy);
        end
        bad = 1'b0;
        for (int i = 0; i < 8; i++) if (dut.v_r[i] !== 8'd0 || dut.w_r[i] !== 64'd0) bad = 1'b1;
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state: v0=%0d w6=%h required 0 0", dut.v_r[0], dut.w_r[6]);
        end
        run_step("post_reset", 8'hFF, got);
        checks++;
        if (got !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_step: out_spike=%h required 00", got);
        end
    endtask

    initial begin
        reset       = 1'b1;
        in_spike    = 8'h00;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        threshold   = 8'h15;
        leak_value  = 8'h01;
        tref        = 4'd2;
        cfg_we      = 1'b0;
        cfg_addr    = 6'd0;
        cfg_data    = 8'h00;
        clear_state = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_zero_input();
        test_refractory();
        test_clamp();
        test_back_to_back();
        test_cfg();
        test_clear_coincident();
        test_threshold_zero();
        test_reset_mid_update();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
